// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch-stage bus bundle: imem request/response, redirect, decode handshake
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        misalign_err;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        output misalign_err
    );

    // Memory / decode / branch-unit side
    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        input  misalign_err
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - credit-limited instruction fetch with PC-tagged buffer and redirect flush (optional IFU_MISALIGN_CHK_EN)
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_if.master  bus
);
    localparam int AW = (FIFO_DEPTH > 4) ? 3 : (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

    typedef logic [CW-1:0] cnt_t;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    cnt_t          outstanding;
    cnt_t          drop_cnt;
    cnt_t          count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   fifo_word [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic          halted;
    logic          pop;
    logic          issue;
    logic          push;
    logic [31:0]   target;
    logic [CW:0]   credit_used;

    // Redirect target; without the misalign check the low bits are simply ignored
    always_comb begin
        target = bus.redirect_pc;
`ifndef IFU_MISALIGN_CHK_EN
        target[1:0] = 2'b00;
`endif
    end

    // A redirect hides the head entry so decode never sees a flushed word
    assign bus.inst_valid = (count != '0) && !bus.redirect_valid;
    assign bus.inst       = fifo_word[rd_ptr];
    assign bus.inst_pc    = fifo_pc[rd_ptr];
    assign pop            = bus.inst_valid && bus.inst_ready;

    // Credits cover both in-flight and buffered words, so a response can never overflow the FIFO
    assign credit_used  = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
    assign bus.imem_req = rst_n && !bus.redirect_valid && !halted && (credit_used < DEPTH_W);
    assign bus.imem_addr = fetch_pc;
    assign issue        = bus.imem_req && bus.imem_gnt;
    assign push         = bus.imem_rvalid && (drop_cnt == '0) && !bus.redirect_valid;

    // PC, credit, drop and FIFO pointer bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc    <= target;
            resp_pc     <= target;
            outstanding <= outstanding - cnt_t'(bus.imem_rvalid);
            drop_cnt    <= outstanding - cnt_t'(bus.imem_rvalid);
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            case ({issue, bus.imem_rvalid})
                2'b10:   outstanding <= outstanding + cnt_t'(1);
                2'b01:   outstanding <= outstanding - cnt_t'(1);
                default: outstanding <= outstanding;
            endcase
            if (bus.imem_rvalid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - cnt_t'(1);
            end
            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // Buffer storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

`ifdef IFU_MISALIGN_CHK_EN
    // Misaligned redirect halts fetch until an aligned redirect arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (bus.redirect_valid) begin
            halted <= |bus.redirect_pc[1:0];
        end
    end
    assign bus.misalign_err = halted;
`else
    assign halted           = 1'b0;
    assign bus.misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;
    localparam logic [31:0] KEY = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    req_t        pend[$];
    logic [31:0] got[$];
    logic [31:0] iss[$];
    logic [63:0] vld_hist;
    logic [63:0] req_hist;
    int          cyc;
    int          lat;
    int          n_checks = 0;
    int          n_fail = 0;
    int          base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset(input int l);
        rst_n = 1'b0;
        lat = l;
        bus.imem_gnt = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        pend.delete();
        got.delete();
        iss.delete();
        vld_hist = '0;
        req_hist = '0;
        @(negedge clk);
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_misalign", 32'(bus.misalign_err), 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // One cycle: drive inputs at negedge, model the memory, sample outputs, advance
    task automatic tick(input logic rdir, input logic [31:0] rpc, input logic rdy);
        req_t r;
        bus.redirect_valid = rdir;
        bus.redirect_pc = rpc;
        bus.inst_ready = rdy;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata = pend[0].addr ^ KEY;
            pend.delete(0);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata = '0;
        end
        #1;
        vld_hist[cyc] = bus.inst_valid;
        req_hist[cyc] = bus.imem_req;
        if (bus.imem_req && bus.imem_gnt) begin
            r.addr = bus.imem_addr;
            r.due = cyc + lat;
            pend.push_back(r);
            iss.push_back(bus.imem_addr);
        end
        if (bus.inst_valid && bus.inst_ready) begin
            got.push_back(bus.inst_pc);
            check("inst_word", bus.inst, bus.inst_pc ^ KEY);
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        // Streaming from reset, 1-cycle memory
        do_reset(1);
        for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b1);
        check("s1_first_addr", iss[0], 32'h0);
        check("s1_req_c0", 32'(req_hist[0]), 32'd1);
        check("s1_valid_pattern", 32'(vld_hist[7:0]), 32'hFC);
        check("s1_pop_count", got.size(), 32'd6);
        for (int i = 0; i < 6; i++) check("s1_pc", got[i], 32'(4 * i));

        // Decode stall fills the buffer, then drains with no gap
        do_reset(1);
        for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0, '0, 1'b0);
        check("s2_req_stalled", 32'(req_hist[13:4]), 32'd0);
        check("s2_valid_held", 32'(vld_hist[13]), 32'd1);
        for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b1);
        check("s2_pop_count", got.size(), 32'd10);
        for (int i = 0; i < 10; i++) check("s2_pc", got[i], 32'(4 * i));

        // Redirect with two words in flight on a 3-cycle memory
        do_reset(3);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        tick(1'b1, 32'h100, 1'b1);
        check("s3_req_redirect", 32'(req_hist[2]), 32'd0);
        for (int i = 0; i < 13; i++) tick(1'b0, '0, 1'b1);
        check("s3_issue_target", iss[2], 32'h100);
        check("s3_pc0", got[0], 32'h100);
        check("s3_pc1", got[1], 32'h104);
        check("s3_pc2", got[2], 32'h108);

        // Redirect coinciding with rvalid and a would-be pop
        do_reset(1);
        for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1);
        tick(1'b1, 32'h40, 1'b1);
        check("s4_valid_redirect", 32'(vld_hist[4]), 32'd0);
        check("s4_no_pop", got.size(), 32'd2);
        for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b1);
        check("s4_issue_target", iss[4], 32'h40);
        check("s4_valid_t2", 32'(vld_hist[6]), 32'd0);
        check("s4_valid_t3", 32'(vld_hist[7]), 32'd1);
        check("s4_pc2", got[2], 32'h40);
        check("s4_pc3", got[3], 32'h44);

        // 32-bit PC wrap
        do_reset(1);
        tick(1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1);
        check("s5_addr0", iss[0], 32'hFFFF_FFF8);
        check("s5_addr1", iss[1], 32'hFFFF_FFFC);
        check("s5_addr2", iss[2], 32'h0000_0000);
        check("s5_pc0", got[0], 32'hFFFF_FFF8);
        check("s5_pc2", got[2], 32'h0000_0000);

        // Misaligned redirect, then an aligned one
        do_reset(1);
        tick(1'b1, 32'h102, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1);
`ifdef IFU_MISALIGN_CHK_EN
        check("s6_misalign_set", 32'(bus.misalign_err), 32'd1);
        check("s6_halted_no_issue", iss.size(), 32'd0);
`else
        check("s6_misalign_tied", 32'(bus.misalign_err), 32'd0);
        check("s6_forced_align", iss[0], 32'h100);
`endif
        base = iss.size();
        tick(1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1);
        check("s6_misalign_clear", 32'(bus.misalign_err), 32'd0);
        check("s6_resume_addr", iss[base], 32'h200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage directly upstream of the instruction decoder/controller. Holds the fetch PC and issues in-order word requests to instruction memory with a credit-limited number outstanding. Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. Accepts a redirect (branch/jump target) that flushes buffered and in-flight instructions.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset; must be word-aligned.
- FIFO_DEPTH, 2: instruction buffer entries, and also the cap on outstanding plus buffered words; power of 2, range 2..8.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word address of the request (equals fetch_pc).
- imem_gnt  in  1  memory accepts the request this cycle (req && gnt = issued).
- imem_rvalid  in  1  response word valid; responses return in issue order, at least 1 cycle after grant.
- imem_rdata  in  32  response instruction word.
- redirect_valid  in  1  redirect fetch to redirect_pc this cycle.
- redirect_pc  in  32  new fetch target.
- inst_valid  out  1  inst/inst_pc valid toward decode.
- inst  out  32  instruction word, which drives the decoder's inst input.
- inst_pc  out  32  PC of inst.
- inst_ready  in  1  decode consumes inst this cycle.
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- State: fetch_pc, resp_pc, outstanding count (0..FIFO_DEPTH), drop_cnt (0..FIFO_DEPTH), FIFO of {pc, word}, count.
- Reset values: fetch_pc = resp_pc = RESET_PC; outstanding = drop_cnt = count = 0; imem_req = 0 while rst_n low; inst_valid = 0; misalign_err = 0. inst and inst_pc are don't-care while inst_valid = 0.
- pop = inst_valid && inst_ready.
- imem_req = !redirect_valid && !halted && (outstanding + count − pop < FIFO_DEPTH). The term is combinational on inst_ready.
- Issue (req && gnt): fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC → 0) and outstanding++.
- Response (rvalid):
  - outstanding−− in every case.
  - If drop_cnt > 0: drop_cnt−− and the word is discarded.
  - Otherwise push {resp_pc, imem_rdata} and resp_pc += 4.
  - The credit rule guarantees no push into a full FIFO.
- Simultaneous issue and response: outstanding is unchanged.
- Simultaneous push and pop: count is unchanged, and a push into an empty FIFO is visible on the next cycle.
- Redirect has highest priority in its cycle:
  - FIFO flushed (count = 0) and any pop ignored.
  - inst_valid forced 0 in that cycle.
  - imem_req forced 0.
  - fetch_pc = resp_pc = target.
  - outstanding_next = outstanding − rvalid.
  - drop_cnt_next = outstanding − rvalid. A response arriving in the redirect cycle is discarded.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed from outstanding each time.
- Reset asserted mid-operation clears all state immediately. Instruction memory is reset by the same rst_n, so no stale responses arrive afterwards.

## Timing
- Earliest fetch: imem_req high in the first clk after rst_n deasserts, with imem_addr = RESET_PC.
- Issue to inst_valid: minimum 2 cycles (grant at T, rvalid at T+1, inst_valid at T+2).
- Throughput: sustained 1 instruction/cycle with a 1-cycle memory, FIFO_DEPTH ≥ 2, and inst_ready held high.
- Redirect at T: first request to the target at T+1; first target instruction at inst at T+3 earliest.
- inst_ready low: the FIFO fills, then imem_req drops once outstanding + count = FIFO_DEPTH. No words are lost.

## Configuration
- IFU_MISALIGN_CHK_EN defined:
  - A redirect with redirect_pc[1:0] ≠ 0 sets misalign_err and sets halted (imem_req held 0).
  - The flush still occurs.
  - Both clear on the next redirect with an aligned target, or on reset.
- Not defined:
  - redirect_pc[1:0] is forced to 00.
  - misalign_err is tied 0 and halted never sets.

## Test plan
- Reset release with RESET_PC=0, gnt tied 1, 1-cycle rvalid, inst_ready=1 → inst_valid every cycle from T+2, inst_pc = 0,4,8,…, inst = memory words in order.
- inst_ready=0 for 10 cycles with FIFO_DEPTH=2 → imem_req low after 2 words are held; on release, PCs continue with no gap or duplicate.
- Redirect to 0x100 while 2 words are in flight (3-cycle memory latency) → both in-flight responses dropped; next inst_pc = 0x100 then 0x104.
- Redirect in the same cycle as rvalid and inst_ready=1 → that word is discarded, no pop occurs, and inst_valid is 0 in that cycle.
- fetch_pc at 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With IFU_MISALIGN_CHK_EN defined, redirect to 0x102 → misalign_err=1 and imem_req stays 0; a later redirect to 0x200 clears the flag and fetch resumes at 0x200. Without the macro, the same redirect fetches 0x100.
